pcileech_cfgspace_mf: RTL

Parametrised multi-function PCIe configuration-space engine. It is the successor to the fixed 8-function config wrapper, sitting between the TLP config-request decoder and the completion generator in the clk_pcie domain. It adds:
- per-dword RW and RW1C masks
- BAR sizing
- valid/ready handshakes with an in-order response buffer
- unsupported-function flagging
- a mask-bypassing override port for the system-side loader

---
 rtl/pcileech_cfgspace_pkg.sv | 30 +++
 rtl/pcileech_cfgspace_rspfifo.sv | 62 ++++++
 rtl/pcileech_cfgspace_mf.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pcileech_cfgspace_pkg.sv
// rtl/pcileech_cfgspace_pkg.sv - shared types and constants for the multi-function config-space engine
package pcileech_cfgspace_pkg;

    localparam logic [1:0] OVR_DATA  = 2'd0;
    localparam logic [1:0] OVR_WMASK = 2'd1;
    localparam logic [1:0] OVR_W1C   = 2'd2;

    localparam int CMD_DW    = 1;
    // Tag field width carried through the response buffer; TAG_W must not exceed it.
    localparam int RSP_TAG_W = 8;

    typedef struct packed {
        logic                 wr;
        logic                 ur;
        logic [RSP_TAG_W-1:0] tag;
        logic [31:0]          data;
    } rsp_t;

    // RW bits take wdata, then any W1C bit written as 1 is cleared; disabled bytes keep old.
    function automatic logic [31:0] cfg_merge(input logic [31:0] old, input logic [31:0] wmask,
                                              input logic [31:0] w1c, input logic [31:0] wdata,
                                              input logic [3:0] be);
        logic [31:0] bmask;
        logic [31:0] tmp;
        bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        tmp   = ((old & ~wmask) | (wdata & wmask)) & ~(wdata & w1c);
        return (old & ~bmask) | (tmp & bmask);
    endfunction

endpackage

// File: rtl/pcileech_cfgspace_rspfifo.sv
// rtl/pcileech_cfgspace_rspfifo.sv - two-entry in-order response buffer
module pcileech_cfgspace_rspfifo
    import pcileech_cfgspace_pkg::*;
(
    input  logic       clk_pcie,
    input  logic       rst_n,
    input  logic       push,
    input  rsp_t       push_data,
    input  logic       pop,
    output logic       out_valid,
    output rsp_t       out_data,
    output logic [1:0] count
);

    rsp_t       e0_q, e0_d;
    rsp_t       e1_q, e1_d;
    logic [1:0] count_q, count_d;

    // e0 is always the head; a pop shifts e1 forward.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) e0_d = push_data;
                else                 e1_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    e0_d = push_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = e0_q;
    assign count     = count_q;

endmodule

// File: rtl/pcileech_cfgspace_mf.sv
// rtl/pcileech_cfgspace_mf.sv - multi-function PCIe config space with masks, override port and response buffer
module pcileech_cfgspace_mf
    import pcileech_cfgspace_pkg::*;
#(
    parameter int NUM_FUNC   = 8,
    parameter int CFG_DW     = 256,
    parameter int AW         = $clog2(CFG_DW),
    parameter int TAG_W      = 8,
    parameter int CMD_THRESH = 16
) (
    input  logic                clk_pcie,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [2:0]          req_func,
    input  logic [AW-1:0]       req_addr,
    input  logic [3:0]          req_be,
    input  logic [31:0]         req_wdata,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_wr,
    output logic                rsp_ur,
    output logic [31:0]         rsp_data,
    output logic [TAG_W-1:0]    rsp_tag,
    input  logic                ovr_valid,
    input  logic [1:0]          ovr_sel,
    input  logic [2:0]          ovr_func,
    input  logic [AW-1:0]       ovr_addr,
    input  logic [31:0]         ovr_data,
    output logic [NUM_FUNC-1:0] driver_seen,
    output logic [31:0]         debug_status
);

    localparam int FW = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1;

    logic [31:0] data_mem  [NUM_FUNC][CFG_DW];
    logic [31:0] wmask_mem [NUM_FUNC][CFG_DW];
    logic [31:0] w1c_mem   [NUM_FUNC][CFG_DW];

    logic          req_fire, req_sup, ovr_sup, cmd_hit;
    logic [FW-1:0] req_fidx, ovr_fidx;
    logic [31:0]   rd_data, wr_val;

    rsp_t          stage_rsp_q, stage_rsp_d, fifo_out;
    logic          stage_valid_q, stage_valid_d;
    logic [1:0]    fifo_count;
    logic          fifo_valid;

    logic [7:0]          cmd_cnt_q [NUM_FUNC];
    logic [7:0]          cmd_cnt_d [NUM_FUNC];
    logic [NUM_FUNC-1:0] driver_seen_q, driver_seen_d;
    logic [15:0]         total_q, total_d;
    logic [31:0]         debug_q, debug_d;
    logic [7:0]          seen8;

    assign req_sup  = (int'(req_func) < NUM_FUNC);
    assign ovr_sup  = (int'(ovr_func) < NUM_FUNC);
    assign req_fidx = req_sup ? req_func[FW-1:0] : '0;
    assign ovr_fidx = ovr_sup ? ovr_func[FW-1:0] : '0;

    // The override port owns the storage write port, so requests are held off while it is active.
    assign req_ready = rst_n && !ovr_valid
                       && (({1'b0, fifo_count} + {2'b00, stage_valid_q}) < 3'd2);
    assign req_fire  = req_valid && req_ready;

    assign rd_data = data_mem[req_fidx][req_addr];
    assign wr_val  = cfg_merge(rd_data, wmask_mem[req_fidx][req_addr],
                               w1c_mem[req_fidx][req_addr], req_wdata, req_be);

    always_ff @(posedge clk_pcie) begin
        if (ovr_valid && ovr_sup) begin
            case (ovr_sel)
                OVR_DATA:  data_mem[ovr_fidx][ovr_addr]  <= ovr_data;
                OVR_WMASK: wmask_mem[ovr_fidx][ovr_addr] <= ovr_data;
                OVR_W1C:   w1c_mem[ovr_fidx][ovr_addr]   <= ovr_data;
                default: ;
            endcase
        end else if (req_fire && req_wr && req_sup) begin
            data_mem[req_fidx][req_addr] <= wr_val;
        end
    end

    always_comb begin
        stage_valid_d    = req_fire;
        stage_rsp_d.wr   = req_wr;
        stage_rsp_d.ur   = !req_sup;
        stage_rsp_d.tag  = RSP_TAG_W'(req_tag);
        stage_rsp_d.data = req_wr ? 32'h0 : (req_sup ? rd_data : 32'hFFFF_FFFF);
    end

    assign cmd_hit = req_fire && req_wr && req_sup && req_be[0] && (req_addr == AW'(CMD_DW));

    always_comb begin
        cmd_cnt_d     = cmd_cnt_q;
        driver_seen_d = driver_seen_q;
        if (cmd_hit && (cmd_cnt_q[req_fidx] != 8'hFF))
            cmd_cnt_d[req_fidx] = cmd_cnt_q[req_fidx] + 8'd1;
        for (int f = 0; f < NUM_FUNC; f++)
            if (cmd_cnt_d[f] == 8'(CMD_THRESH)) driver_seen_d[f] = 1'b1;
        total_d = total_q + {15'd0, req_fire};
        seen8   = '0;
        seen8[NUM_FUNC-1:0] = driver_seen_q;
        debug_d = {seen8, 8'h00, total_q};
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            stage_rsp_q   <= '0;
            for (int f = 0; f < NUM_FUNC; f++) cmd_cnt_q[f] <= '0;
            driver_seen_q <= '0;
            total_q       <= '0;
            debug_q       <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_rsp_q   <= stage_rsp_d;
            cmd_cnt_q     <= cmd_cnt_d;
            driver_seen_q <= driver_seen_d;
            total_q       <= total_d;
            debug_q       <= debug_d;
        end
    end

    pcileech_cfgspace_rspfifo u_rspfifo (
        .clk_pcie  (clk_pcie),
        .rst_n     (rst_n),
        .push      (stage_valid_q),
        .push_data (stage_rsp_q),
        .pop       (fifo_valid && rsp_ready),
        .out_valid (fifo_valid),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    assign rsp_valid    = fifo_valid;
    assign rsp_wr       = fifo_out.wr;
    assign rsp_ur       = fifo_out.ur;
    assign rsp_data     = fifo_out.data;
    assign rsp_tag      = fifo_out.tag[TAG_W-1:0];
    assign driver_seen  = driver_seen_q;
    assign debug_status = debug_q;

endmodule
